// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: slew-limited PWM duty controller with overcurrent lockout.
// Duty moves at most STEP per PWM period toward the enabled target.
module duty_ramp_ctrl #(
    parameter int STEP       = 8,
    parameter int FAULT_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] tgt_duty,
    input  logic        tgt_vld,
    output logic        tgt_rdy,
    input  logic        en,
    input  logic        PWM_synch,
    input  logic        ovr_curr,
    output logic [10:0] duty,
    output logic        ramping,
    output logic        fault
);
    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD,
        FAULT
    } state_e;

    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [7:0]  HOLD_W = 8'(FAULT_HOLD);

    state_e      state_q, state_d;
    logic [10:0] duty_q, duty_d;
    logic [10:0] tgt_q, tgt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ramping_q, fault_q;

    logic [10:0] eff_tgt;
    logic [10:0] duty_step;
    logic [11:0] diff;
    logic        going_up;

    assign eff_tgt  = en ? tgt_q : '0;
    assign going_up = eff_tgt > duty_q;
    assign diff     = going_up ? ({1'b0, eff_tgt} - {1'b0, duty_q})
                               : ({1'b0, duty_q} - {1'b0, eff_tgt});

    // A full STEP is only taken when it cannot reach eff_tgt, so no wrap.
    always_comb begin
        duty_step = eff_tgt;
        if (diff > STEP_W) begin
            if (going_up) begin
                duty_step = duty_q + STEP_W[10:0];
            end else begin
                duty_step = duty_q - STEP_W[10:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (ovr_curr) begin
            state_d = FAULT;
            duty_d  = '0;
            tgt_d   = '0;
            cnt_d   = '0;
        end else if (state_q == FAULT) begin
            if (cnt_q >= HOLD_W) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (PWM_synch) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            // eff_tgt still reflects the pre-acceptance target here.
            if (tgt_vld) begin
                tgt_d = tgt_duty;
            end
            if (PWM_synch) begin
                duty_d = duty_step;
            end
            if (PWM_synch && (duty_step == eff_tgt)) begin
                state_d = (eff_tgt == '0) ? IDLE : HOLD;
            end else if (eff_tgt != duty_q) begin
                state_d = RAMP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            ramping_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            ramping_q <= (state_d == RAMP);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign tgt_rdy = (state_q != FAULT);
    assign duty    = duty_q;
    assign ramping = ramping_q;
    assign fault   = fault_q;

endmodule

// File: doc/duty_ramp_ctrl.md
DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 8: maximum duty change per PWM period, range 1..2047.
REQ-002 SHALL have parameter FAULT_HOLD, default 16: fault-free PWM periods required before leaving FAULT, range 1..255.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port tgt_duty, input, 11: requested target duty.
REQ-006 SHALL have port tgt_vld, input, 1: tgt_duty valid.
REQ-007 SHALL have port tgt_rdy, output, 1: block can accept a target.
REQ-008 SHALL have port en, input, 1: drive enable; low forces the effective target to 0.
REQ-009 SHALL have port PWM_synch, input, 1: one-cycle pulse at the start of each PWM period, from the PWM generator.
REQ-010 SHALL have port ovr_curr, input, 1: overcurrent flag, already synchronous to clk.
REQ-011 SHALL have port duty, output, 11: registered duty fed to the PWM generator's duty input.
REQ-012 SHALL have port ramping, output, 1: high while in state RAMP.
REQ-013 SHALL have port fault, output, 1: high while in state FAULT.

Function
REQ-014 SHALL implement states IDLE, RAMP, HOLD and FAULT in a registered state machine.
REQ-015 SHALL drive tgt_rdy combinationally as (state != FAULT).
REQ-016 SHALL register tgt_duty into tgt_reg on a cycle with tgt_vld && tgt_rdy; tgt_reg is visible from the next cycle.
REQ-017 SHALL let a later accepted target overwrite tgt_reg; no queuing.
REQ-018 SHALL define the effective target eff_tgt as tgt_reg when en=1, else 0.
REQ-019 SHALL update duty in RAMP, HOLD and IDLE only on a cycle with PWM_synch=1; the new value is present on the following cycle.
REQ-020 SHALL use the pre-acceptance tgt_reg at a PWM_synch that coincides with an acceptance; the new target takes effect at the next PWM_synch.
REQ-021 SHALL compute each step from the unsigned difference of duty and eff_tgt, evaluated at 12 bits.
REQ-022 SHALL set duty to eff_tgt when that difference is <= STEP, and otherwise move duty toward eff_tgt by exactly STEP.
REQ-023 SHALL never let duty wrap: duty saturates within 0..2047 and never overshoots eff_tgt.
REQ-024 SHALL move from IDLE to RAMP when eff_tgt != duty.
REQ-025 SHALL move from RAMP to HOLD on the synch update where duty becomes eff_tgt and eff_tgt != 0.
REQ-026 SHALL move from RAMP to IDLE on that same update when eff_tgt = 0.
REQ-027 SHALL move from HOLD to RAMP when eff_tgt != duty.
REQ-028 SHALL enter FAULT from any state on the cycle after ovr_curr=1, regardless of PWM_synch.
REQ-029 SHALL, on FAULT entry, clear duty to 0 and tgt_reg to 0 on that same cycle.
REQ-030 SHALL hold duty at 0 in FAULT and ignore tgt_vld.
REQ-031 SHALL keep a hold counter in FAULT that counts PWM_synch pulses while ovr_curr=0.
REQ-032 SHALL clear the hold counter on any cycle with ovr_curr=1.
REQ-033 SHALL leave FAULT for IDLE on the cycle after the counter reaches FAULT_HOLD.
REQ-034 SHALL give ovr_curr priority over PWM_synch, handshake and en on the same cycle.
REQ-035 SHALL register all outputs except tgt_rdy.

Reset
REQ-036 SHALL, on rst_n=0 asynchronously, set state=IDLE, duty=0, tgt_reg=0, hold counter=0, ramping=0 and fault=0; tgt_rdy is then 1.
REQ-037 SHALL, on reset asserted mid-ramp or mid-fault, drop duty to 0 immediately and keep no memory of the prior target.

Verification
REQ-038 SHALL cover ramp-up: STEP=8, en=1, accept tgt_duty=20 from IDLE -> duty 8, 16, 20 on successive synchs; ramping=1 during the ramp; HOLD after 20.
REQ-039 SHALL cover ramp-down: in HOLD at 1000, accept 990 -> duty 992 then 990; state HOLD.
REQ-040 SHALL cover disable: in HOLD at 12, en=0 -> duty 4 then 0; state IDLE; ramping=0.
REQ-041 SHALL cover coincident accept and synch: tgt_reg=100, duty=100, accept 200 on a synch cycle -> duty stays 100; 108 at the next synch.
REQ-042 SHALL cover fault: ovr_curr pulsed while duty=500 -> duty=0 and fault=1 next cycle; tgt_vld ignored; ovr_curr re-pulsed after 5 synchs restarts the count; IDLE after 16 clean synchs.
REQ-043 SHALL cover wide targets: STEP=2047, accept 2047 from 0 -> duty 2047 in one synch; then en=0 -> duty 0 in one synch; no wrap.
